// File: rtl/dcache_ctrl_if.sv
// CPU-side and memory-side signal bundle of the data cache controller.
// slave is the cache's view; master is the CPU-pipeline/memory-model view.
interface dcache_ctrl_if #(
  parameter int MEM_WIDTH = 256
);
  logic [31:0]          p1_addr_i;
  logic [31:0]          p1_data_i;
  logic                 p1_MemRead_i;
  logic                 p1_MemWrite_i;
  logic [31:0]          p1_data_o;
  logic                 p1_stall_o;
  logic                 mem_enable_o;
  logic                 mem_write_o;
  logic [31:0]          mem_addr_o;
  logic [MEM_WIDTH-1:0] mem_data_o;
  logic [MEM_WIDTH-1:0] mem_data_i;
  logic                 mem_ack_i;

  modport slave (
    input  p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i, mem_data_i, mem_ack_i,
    output p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport master (
    output p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i, mem_data_i, mem_ack_i,
    input  p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache: hits complete combinationally in the request cycle,
// misses freeze the pipeline via p1_stall_o until write-back/fetch/refill finish on mem_ack_i.
module dcache_ctrl #(
  parameter int NUM_LINES = 32,
  parameter int MEM_WIDTH = 256
) (
  input logic          clk,
  input logic          rst,
  dcache_ctrl_if.slave bus
);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int OFF_W  = $clog2(MEM_WIDTH / 8);
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int WORDS  = MEM_WIDTH / 32;
  localparam int WSEL_W = OFF_W - 2;

  typedef logic [WORDS-1:0][31:0] line_t;
  typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, READMISS, REFILL} state_t;

  state_t               state;
  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  line_t                data_mem [NUM_LINES];

  logic                 mem_en_q;
  logic                 mem_wr_q;
  logic [31:0]          mem_addr_q;
  line_t                mem_dat_q;

  logic [TAG_W-1:0]     req_tag;
  logic [IDX_W-1:0]     idx;
  logic [WSEL_W-1:0]    wsel;
  logic                 addr_unused;
  logic                 req;
  logic                 hit;
  logic                 idle;
  logic                 store_hit;
  logic                 refill;
  line_t                cur_line;

  assign req_tag     = bus.p1_addr_i[31 -: TAG_W];
  assign idx         = bus.p1_addr_i[OFF_W +: IDX_W];
  assign wsel        = bus.p1_addr_i[2 +: WSEL_W];
  assign addr_unused = ^bus.p1_addr_i[1:0];

  assign req       = bus.p1_MemRead_i || bus.p1_MemWrite_i;
  assign hit       = valid[idx] && (tag_mem[idx] == req_tag);
  assign idle      = (state == IDLE);
  assign store_hit = idle && bus.p1_MemWrite_i && hit;
  assign refill    = (state == READMISS) && bus.mem_ack_i;
  assign cur_line  = data_mem[idx];

  // Load data is read before the same-cycle store lands, so read+write shows the old word.
  assign bus.p1_data_o    = (idle && bus.p1_MemRead_i && hit) ? cur_line[wsel] : 32'd0;
  assign bus.p1_stall_o   = !rst && (!idle || (req && !hit));
  assign bus.mem_enable_o = mem_en_q && !rst;
  assign bus.mem_write_o  = mem_wr_q && !rst;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_data_o   = mem_dat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      valid    <= '0;
      dirty    <= '0;
      mem_en_q <= 1'b0;
      mem_wr_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !hit) begin
            state <= MISS;
          end else if (store_hit) begin
            dirty[idx] <= 1'b1;
          end
        end
        MISS: begin
          mem_en_q <= 1'b1;
          if (valid[idx] && dirty[idx]) begin
            state      <= WRITEBACK;
            mem_wr_q   <= 1'b1;
            mem_addr_q <= {tag_mem[idx], idx, {OFF_W{1'b0}}};
            mem_dat_q  <= cur_line;
          end else begin
            state      <= READMISS;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= {req_tag, idx, {OFF_W{1'b0}}};
          end
        end
        WRITEBACK: begin
          if (bus.mem_ack_i) begin
            state      <= READMISS;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= {req_tag, idx, {OFF_W{1'b0}}};
          end
        end
        READMISS: begin
          if (bus.mem_ack_i) begin
            state      <= REFILL;
            mem_en_q   <= 1'b0;
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
          end
        end
        REFILL: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Tag/data arrays are not cleared by reset, only protected from updates during it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (refill) begin
        tag_mem[idx]  <= req_tag;
        data_mem[idx] <= bus.mem_data_i;
      end else if (store_hit) begin
        data_mem[idx][wsel] <= bus.p1_data_i;
      end
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized scoreboard bench for dcache_ctrl against a line-level cache/memory model.
module tb_dcache_ctrl;
  localparam int MW = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_ctrl_if #(.MEM_WIDTH(MW)) bus ();
  dcache_ctrl #(.NUM_LINES(32), .MEM_WIDTH(MW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef enum int {EV_WB, EV_FETCH, EV_CPU} ev_kind_t;
  typedef struct {
    ev_kind_t     kind;
    logic [31:0]  addr;
    logic [255:0] line;
    logic [31:0]  word;
  } exp_t;

  exp_t expq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  bit           m_valid [32];
  bit           m_dirty [32];
  logic [31:0]  m_tag   [32];
  logic [255:0] m_line  [32];
  logic [255:0] backing [int unsigned];

  bit mon_on   = 1'b0;
  bit resp_on  = 1'b1;
  bit req_seen = 1'b0;
  int stray_req = 0;

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(string name, logic [31:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0h with no expectation queued at %0t", name, act, $time);
  endtask

  function automatic logic [255:0] backing_line(int unsigned la);
    logic [255:0] l;
    if (!backing.exists(la)) begin
      for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom();
      backing[la] = l;
    end
    return backing[la];
  endfunction

  // Reference: cache as per-index tag/line table over a line-addressed backing memory.
  task automatic model_issue(logic [31:0] a, logic [31:0] d, bit rd, bit wr);
    int unsigned idx = (a / 32) % 32;
    int unsigned tg  = a / 1024;
    int unsigned w   = (a / 4) % 8;
    exp_t e;
    if (!(m_valid[idx] && m_tag[idx] == tg)) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        e.kind = EV_WB;
        e.addr = m_tag[idx] * 1024 + idx * 32;
        e.line = m_line[idx];
        e.word = '0;
        backing[e.addr / 32] = m_line[idx];
        expq.push_back(e);
      end
      e.kind = EV_FETCH;
      e.addr = tg * 1024 + idx * 32;
      e.line = '0;
      e.word = '0;
      expq.push_back(e);
      m_line[idx]  = backing_line(a / 32);
      m_tag[idx]   = tg;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
    end
    e.kind = EV_CPU;
    e.addr = a;
    e.line = '0;
    e.word = rd ? m_line[idx][w*32 +: 32] : 32'd0;
    expq.push_back(e);
    if (wr) begin
      m_line[idx][w*32 +: 32] = d;
      m_dirty[idx] = 1'b1;
    end
  endtask

  task automatic access(logic [31:0] a, logic [31:0] d, bit rd, bit wr);
    int cyc = 0;
    model_issue(a, d, rd, wr);
    bus.p1_addr_i     = a;
    bus.p1_data_i     = d;
    bus.p1_MemRead_i  = rd;
    bus.p1_MemWrite_i = wr;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.p1_stall_o && cyc < 100);
    if (bus.p1_stall_o) chk("access_timeout", 1, 0);
    @(posedge clk);
    #1;
    bus.p1_MemRead_i  = 1'b0;
    bus.p1_MemWrite_i = 1'b0;
  endtask

  // Memory responder: random-latency ack, fetched lines served from the backing store.
  initial begin
    int wait_cnt = 0;
    int stray_done = 0;
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ack_i = 1'b0;
      if (stray_req != stray_done) begin
        stray_done++;
        bus.mem_ack_i = 1'b1;
      end else if (resp_on && bus.mem_enable_o) begin
        if (wait_cnt == 0) begin
          wait_cnt = $urandom_range(1, 4);
        end else begin
          wait_cnt--;
          if (wait_cnt == 0) begin
            bus.mem_ack_i = 1'b1;
            if (!bus.mem_write_o) bus.mem_data_i = backing_line(bus.mem_addr_o / 32);
          end
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever a memory request or a CPU completion appears.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (bus.mem_enable_o && !req_seen) begin
          req_seen = 1'b1;
          if (expq.size() == 0) begin
            note_fail("mem_req_unexpected", bus.mem_addr_o);
          end else begin
            e = expq.pop_front();
            chk("mem_req_kind", bus.mem_write_o ? EV_WB : EV_FETCH, e.kind);
            chk("mem_req_addr", bus.mem_addr_o, e.addr);
            if (e.kind == EV_WB) chk("wb_line", bus.mem_data_o, e.line);
          end
        end
        if (bus.mem_ack_i) req_seen = 1'b0;
        if ((bus.p1_MemRead_i || bus.p1_MemWrite_i) && !bus.p1_stall_o) begin
          if (expq.size() == 0) begin
            note_fail("cpu_done_unexpected", bus.p1_addr_i);
          end else begin
            e = expq.pop_front();
            chk("cpu_done_kind", EV_CPU, e.kind);
            chk("load_data", bus.p1_data_o, e.word);
          end
        end
      end
    end
  end

  initial begin
    logic [255:0] l;
    logic [31:0]  a;
    int           op;
    int           cyc;
    bus.p1_addr_i     = '0;
    bus.p1_data_i     = '0;
    bus.p1_MemRead_i  = 1'b0;
    bus.p1_MemWrite_i = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", bus.p1_stall_o, 0);
    chk("rst_mem_en", bus.mem_enable_o, 0);
    chk("rst_mem_wr", bus.mem_write_o, 0);
    chk("rst_data", bus.p1_data_o, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_stall", bus.p1_stall_o, 0);
    chk("post_rst_mem_en", bus.mem_enable_o, 0);
    mon_on = 1'b1;

    l = backing_line(32'h40 / 32);
    l[95:64] = 32'hDEADBEEF;
    backing[32'h40 / 32] = l;
    @(posedge clk);
    #1;
    access(32'h0000_0040, 32'h0, 1, 0);
    access(32'h0000_0048, 32'h0, 1, 0);
    access(32'h0000_0044, 32'h1234_5678, 0, 1);
    access(32'h0000_0044, 32'h0, 1, 0);
    access(32'h0000_0440, 32'h0, 1, 0);
    access(32'h0000_0840, 32'h0, 1, 0);
    access(32'h0000_084C, 32'hCAFE_F00D, 1, 1);
    access(32'h0000_084C, 32'h0, 1, 0);

    // Stray ack while idle must be ignored.
    repeat (2) @(posedge clk);
    stray_req++;
    repeat (3) begin
      @(negedge clk);
      chk("stray_ack_stall", bus.p1_stall_o, 0);
      chk("stray_ack_mem_en", bus.mem_enable_o, 0);
    end
    @(posedge clk);
    #1;
    access(32'h0000_084C, 32'h0, 1, 0);
    access(32'h0000_1000, 32'h0, 1, 0);

    // Reset in the middle of a line fetch.
    mon_on  = 1'b0;
    resp_on = 1'b0;
    bus.p1_addr_i    = 32'h0000_1C00;
    bus.p1_MemRead_i = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(bus.mem_enable_o && !bus.mem_write_o) && cyc < 20);
    chk("readmiss_en", bus.mem_enable_o, 1);
    chk("readmiss_wr", bus.mem_write_o, 0);
    chk("readmiss_addr", bus.mem_addr_o, 32'h0000_1C00);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.p1_MemRead_i = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_mem_en", bus.mem_enable_o, 0);
    chk("abort_stall", bus.p1_stall_o, 0);
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    req_seen = 1'b0;
    mon_on   = 1'b1;
    resp_on  = 1'b1;
    @(posedge clk);
    #1;
    access(32'h0000_1000, 32'h0, 1, 0);
    access(32'h0000_0840, 32'h0, 1, 0);

    for (int i = 0; i < 400; i++) begin
      a  = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 5) |
           ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      op = $urandom_range(0, 2);
      access(a, $urandom(), op != 1, op != 0);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    cyc = 0;
    while (expq.size() != 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("queue_drained", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
